// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared types and helpers for the serial CRC engine
// Purpose: FSM state encoding, default accumulator width, width mask and
//          bit-reverse-by-width helpers.
// Ports:   none (package).
package crc_pkg;

    localparam int CRC_MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_SHIFT,
        ST_FINAL
    } crc_state_t;

    // Width code 0 encodes a full 64-bit CRC.
    function automatic logic [CRC_MAX_WIDTH-1:0] crc_mask(input logic [5:0] w);
        logic [CRC_MAX_WIDTH-1:0] m;
        if (w == 6'd0) begin
            m = '1;
        end else begin
            m = (CRC_MAX_WIDTH'(1) << w) - CRC_MAX_WIDTH'(1);
        end
        return m;
    endfunction

    // Reverse the low w bits of v; bits above the width come out as 0.
    function automatic logic [CRC_MAX_WIDTH-1:0] crc_rev(input logic [CRC_MAX_WIDTH-1:0] v,
                                                         input logic [5:0] w);
        logic [CRC_MAX_WIDTH-1:0] r;
        logic [5:0]               top;
        top = w - 6'd1;     // wraps to 63 when w encodes 64
        r   = '0;
        for (int i = 0; i < CRC_MAX_WIDTH; i++) begin
            if (6'(i) <= top) begin
                r[top - 6'(i)] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_step.sv
// rtl/crc_step.sv - one combinational bit step of the CRC accumulator
// Purpose: crc_out = ((crc_in << 1) ^ (fb ? poly : 0)) & mask, fb = crc_in[w-1] ^ bit_in.
// Ports:   crc_in, poly, mask (MAX_WIDTH) - current accumulator, polynomial, width mask
//          width (6)                      - CRC width, 0 means 64
//          bit_in (1)                     - next message bit
//          crc_out (MAX_WIDTH)            - accumulator after this step
module crc_step
    import crc_pkg::*;
#(
    parameter int MAX_WIDTH = CRC_MAX_WIDTH
) (
    input  logic [MAX_WIDTH-1:0] crc_in,
    input  logic [MAX_WIDTH-1:0] poly,
    input  logic [MAX_WIDTH-1:0] mask,
    input  logic [5:0]           width,
    input  logic                 bit_in,
    output logic [MAX_WIDTH-1:0] crc_out
);

    logic [5:0] top;
    logic       fb;

    always_comb begin
        top     = width - 6'd1;     // width code 0 lands on bit 63
        fb      = crc_in[top] ^ bit_in;
        crc_out = ((crc_in << 1) ^ (fb ? poly : '0)) & mask;
    end

endmodule

// File: rtl/crc_serial_engine.sv
// rtl/crc_serial_engine.sv - bit-serial CRC datapath with byte-wise result readout
// Purpose: latches a CRC configuration, assembles nibbles into bytes, shifts each
//          byte through the accumulator, then presents the finished CRC byte by byte.
//          CRC_NIBBLE_STEP_EN: when defined, 4 chained steps per clock (2 clocks/byte).
// Ports:   clk, rst (async, active-high)
//          cfg_width/cfg_reflect_in/cfg_reflect_out/cfg_poly/cfg_init/cfg_xor, cfg_load
//          nib_valid, nib_data, nib_ready - message nibble stream, low nibble first
//          final_req                      - finish message and compute result
//          out_next, out_byte, out_valid  - result readout, LS byte first, wraps
//          busy                           - shifting, or final_req pending
module crc_serial_engine
    import crc_pkg::*;
#(
    parameter int MAX_WIDTH = CRC_MAX_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           cfg_width,
    input  logic                 cfg_reflect_in,
    input  logic                 cfg_reflect_out,
    input  logic [MAX_WIDTH-1:0] cfg_poly,
    input  logic [MAX_WIDTH-1:0] cfg_init,
    input  logic [MAX_WIDTH-1:0] cfg_xor,
    input  logic                 cfg_load,
    input  logic                 nib_valid,
    input  logic [3:0]           nib_data,
    output logic                 nib_ready,
    input  logic                 final_req,
    input  logic                 out_next,
    output logic [7:0]           out_byte,
    output logic                 out_valid,
    output logic                 busy
);

`ifdef CRC_NIBBLE_STEP_EN
    localparam int STEPS = 4;
`else
    localparam int STEPS = 1;
`endif
    localparam logic [2:0] LAST_CNT = 3'((8 / STEPS) - 1);

    crc_state_t           state_q, state_d;
    logic [5:0]           width_q, width_d;
    logic                 refl_in_q, refl_in_d;
    logic                 refl_out_q, refl_out_d;
    logic [MAX_WIDTH-1:0] poly_q, poly_d;
    logic [MAX_WIDTH-1:0] xor_q, xor_d;
    logic [MAX_WIDTH-1:0] crc_q, crc_d;
    logic [MAX_WIDTH-1:0] result_q, result_d;
    logic [3:0]           lo_nib_q, lo_nib_d;
    logic [7:0]           byte_q, byte_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic                 pending_q, pending_d;
    logic                 nib_ready_q, nib_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic [7:0]           out_byte_q, out_byte_d;

    logic [MAX_WIDTH-1:0] mask_cur;
    logic [MAX_WIDTH-1:0] mask_new;
    logic [MAX_WIDTH-1:0] shift_crc;
    logic [MAX_WIDTH-1:0] fin_crc;
    logic                 fin_go;
    logic [7:0]           full_byte;
    logic [6:0]           eff_w;
    logic [2:0]           last_idx;

    assign mask_cur = MAX_WIDTH'(crc_mask(width_q));

    // byte_q always holds the byte MSB-first (reflected on capture if needed),
    // so stage g consumes bit 7-g and the byte shifts left by STEPS per clock.
    genvar g;
    for (g = 0; g < STEPS; g++) begin : g_step
        logic [MAX_WIDTH-1:0] c_in;
        logic [MAX_WIDTH-1:0] c_out;
        if (g == 0) begin : g_first
            assign c_in = crc_q;
        end else begin : g_next
            assign c_in = g_step[g-1].c_out;
        end
        crc_step #(.MAX_WIDTH(MAX_WIDTH)) u_crc_step (
            .crc_in  (c_in),
            .poly    (poly_q),
            .mask    (mask_cur),
            .width   (width_q),
            .bit_in  (byte_q[7-g]),
            .crc_out (c_out)
        );
    end
    assign shift_crc = g_step[STEPS-1].c_out;

    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        refl_in_d  = refl_in_q;
        refl_out_d = refl_out_q;
        poly_d     = poly_q;
        xor_d      = xor_q;
        crc_d      = crc_q;
        result_d   = result_q;
        lo_nib_d   = lo_nib_q;
        byte_d     = byte_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        pending_d  = pending_q;
        fin_go     = 1'b0;
        fin_crc    = crc_q;
        mask_new   = MAX_WIDTH'(crc_mask(cfg_width));
        full_byte  = {nib_data, lo_nib_q};
        eff_w      = (width_q == 6'd0) ? 7'd64 : {1'b0, width_q};
        last_idx   = 3'((eff_w + 7'd7) >> 3) - 3'd1;

        if (cfg_load) begin
            width_d    = cfg_width;
            refl_in_d  = cfg_reflect_in;
            refl_out_d = cfg_reflect_out;
            poly_d     = cfg_poly & mask_new;
            xor_d      = cfg_xor & mask_new;
            crc_d      = cfg_init & mask_new;
            cnt_d      = 3'd0;
            idx_d      = 3'd0;
            pending_d  = 1'b0;
            state_d    = ST_LO;
        end else begin
            case (state_q)
                ST_LO: begin
                    // final_req wins; a nibble offered in the same cycle is dropped
                    if (final_req) begin
                        fin_go = 1'b1;
                    end else if (nib_valid) begin
                        lo_nib_d = nib_data;
                        state_d  = ST_HI;
                    end
                end
                ST_HI: begin
                    if (final_req) begin
                        fin_go = 1'b1;
                    end else if (nib_valid) begin
                        for (int i = 0; i < 8; i++) begin
                            byte_d[i] = refl_in_q ? full_byte[7-i] : full_byte[i];
                        end
                        cnt_d   = 3'd0;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    crc_d  = shift_crc;
                    byte_d = byte_q << STEPS;
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == LAST_CNT) begin
                        if (pending_q || final_req) begin
                            fin_go  = 1'b1;
                            fin_crc = shift_crc;
                        end else begin
                            state_d = ST_LO;
                        end
                    end else if (final_req) begin
                        pending_d = 1'b1;
                    end
                end
                ST_FINAL: begin
                    if (out_next) begin
                        idx_d = (idx_q == last_idx) ? 3'd0 : idx_q + 3'd1;
                    end
                end
                default: ;
            endcase

            if (fin_go) begin
                result_d  = ((refl_out_q ? MAX_WIDTH'(crc_rev(CRC_MAX_WIDTH'(fin_crc), width_q))
                                         : fin_crc) ^ xor_q) & mask_cur;
                idx_d     = 3'd0;
                pending_d = 1'b0;
                state_d   = ST_FINAL;
            end
        end

        nib_ready_d = (state_d == ST_LO) || (state_d == ST_HI);
        out_valid_d = (state_d == ST_FINAL);
        busy_d      = (state_d == ST_SHIFT);
        out_byte_d  = out_valid_d ? result_d[{idx_d, 3'b000} +: 8] : 8'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            width_q     <= '0;
            refl_in_q   <= 1'b0;
            refl_out_q  <= 1'b0;
            poly_q      <= '0;
            xor_q       <= '0;
            crc_q       <= '0;
            result_q    <= '0;
            lo_nib_q    <= '0;
            byte_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            nib_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_byte_q  <= '0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            refl_in_q   <= refl_in_d;
            refl_out_q  <= refl_out_d;
            poly_q      <= poly_d;
            xor_q       <= xor_d;
            crc_q       <= crc_d;
            result_q    <= result_d;
            lo_nib_q    <= lo_nib_d;
            byte_q      <= byte_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            nib_ready_q <= nib_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_byte_q  <= out_byte_d;
        end
    end

    assign nib_ready = nib_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_byte  = out_byte_q;

endmodule

// File: tb/tb_crc_serial_engine.sv
// tb/tb_crc_serial_engine.sv - directed self-checking bench for crc_serial_engine
module tb_crc_serial_engine;

`ifdef CRC_NIBBLE_STEP_EN
    localparam int SHIFT_CLKS = 2;
`else
    localparam int SHIFT_CLKS = 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  cfg_width;
    logic        cfg_reflect_in;
    logic        cfg_reflect_out;
    logic [63:0] cfg_poly;
    logic [63:0] cfg_init;
    logic [63:0] cfg_xor;
    logic        cfg_load;
    logic        nib_valid;
    logic [3:0]  nib_data;
    logic        nib_ready;
    logic        final_req;
    logic        out_next;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    crc_serial_engine #(.MAX_WIDTH(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_width       (cfg_width),
        .cfg_reflect_in  (cfg_reflect_in),
        .cfg_reflect_out (cfg_reflect_out),
        .cfg_poly        (cfg_poly),
        .cfg_init        (cfg_init),
        .cfg_xor         (cfg_xor),
        .cfg_load        (cfg_load),
        .nib_valid       (nib_valid),
        .nib_data        (nib_data),
        .nib_ready       (nib_ready),
        .final_req       (final_req),
        .out_next        (out_next),
        .out_byte        (out_byte),
        .out_valid       (out_valid),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!nib_ready && t < 40) begin
            tick();
            t++;
        end
        if (!nib_ready) check_eq("nib_ready_timeout", nib_ready, 1);
    endtask

    task automatic send_nib(input logic [3:0] n);
        wait_ready();
        nib_valid = 1'b1;
        nib_data  = n;
        tick();
        nib_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[3:0]);
        send_nib(b[7:4]);
    endtask

    task automatic send_msg(input int count);
        for (int i = 0; i < count; i++) send_byte(msg[i]);
    endtask

    task automatic configure(input logic [5:0] w, input logic ri, input logic ro,
                             input logic [63:0] p, input logic [63:0] ini, input logic [63:0] x);
        cfg_width       = w;
        cfg_reflect_in  = ri;
        cfg_reflect_out = ro;
        cfg_poly        = p;
        cfg_init        = ini;
        cfg_xor         = x;
        cfg_load        = 1'b1;
        tick();
        cfg_load        = 1'b0;
    endtask

    task automatic finish_msg();
        wait_ready();
        final_req = 1'b1;
        tick();
        final_req = 1'b0;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        check_eq(tag, out_byte, exp);
        out_next = 1'b1;
        tick();
        out_next = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cfg_width = '0; cfg_reflect_in = 0; cfg_reflect_out = 0;
        cfg_poly = '0; cfg_init = '0; cfg_xor = '0; cfg_load = 0;
        nib_valid = 0; nib_data = '0; final_req = 0; out_next = 0;
        tick();
        tick();
        check_eq("rst_nib_ready", nib_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_byte", out_byte, 0);
        check_eq("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // CRC-8 with handshake timing checks on the last byte
        configure(6'd8, 0, 0, 64'h07, 64'h0, 64'h0);
        check_eq("ready_after_load", nib_ready, 1);
        send_msg(8);
        send_nib(4'h9);
        send_nib(4'h3);
        check_eq("shift_busy", busy, 1);
        check_eq("shift_not_ready", nib_ready, 0);
        repeat (SHIFT_CLKS - 1) tick();
        check_eq("shift_last_not_ready", nib_ready, 0);
        tick();
        check_eq("ready_after_shift", nib_ready, 1);
        finish_msg();
        check_eq("crc8_valid", out_valid, 1);
        check_eq("final_not_ready", nib_ready, 0);
        expect_byte("crc8_b0", 8'hF4);
        expect_byte("crc8_wrap", 8'hF4);

        // CRC-16/ARC
        configure(6'd16, 1, 1, 64'h8005, 64'h0, 64'h0);
        send_msg(9);
        finish_msg();
        expect_byte("arc_b0", 8'h3D);
        expect_byte("arc_b1", 8'hBB);
        expect_byte("arc_wrap", 8'h3D);

        // CRC-32
        configure(6'd32, 1, 1, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF);
        send_msg(9);
        finish_msg();
        expect_byte("crc32_b0", 8'h26);
        expect_byte("crc32_b1", 8'h39);
        expect_byte("crc32_b2", 8'hF4);
        expect_byte("crc32_b3", 8'hCB);
        expect_byte("crc32_wrap", 8'h26);

        // Abort: reload 3 cycles into SHIFT, then full CRC-8 message
        configure(6'd8, 0, 0, 64'h07, 64'h0, 64'h0);
        send_byte(msg[0]);
        tick();
        tick();
        configure(6'd8, 0, 0, 64'h07, 64'h0, 64'h0);
        check_eq("abort_ready", nib_ready, 1);
        check_eq("abort_busy", busy, 0);
        send_msg(9);
        finish_msg();
        expect_byte("abort_crc8", 8'hF4);

        // final_req in HI, with a nibble offered in the same cycle: both dropped
        configure(6'd8, 0, 0, 64'h07, 64'h0, 64'h0);
        send_msg(2);
        send_nib(4'h3);
        wait_ready();
        nib_valid = 1'b1;
        nib_data  = 4'h3;
        final_req = 1'b1;
        tick();
        nib_valid = 1'b0;
        final_req = 1'b0;
        check_eq("hi_final_valid", out_valid, 1);
        check_eq("hi_final_byte", out_byte, 8'h72);

        // final_req during SHIFT of the last byte
        configure(6'd8, 0, 0, 64'h07, 64'h0, 64'h0);
        send_msg(8);
        send_nib(4'h9);
        send_nib(4'h3);
        final_req = 1'b1;
        tick();
        final_req = 1'b0;
        check_eq("pend_busy", busy, 1);
        check_eq("pend_not_valid", out_valid, 0);
        repeat (SHIFT_CLKS - 2) tick();
        check_eq("pend_busy_late", busy, 1);
        check_eq("pend_not_valid_late", out_valid, 0);
        tick();
        check_eq("pend_valid", out_valid, 1);
        check_eq("pend_busy_clear", busy, 0);
        check_eq("pend_byte", out_byte, 8'hF4);

        // Width 1 boundary: parity of "1" = 1
        configure(6'd1, 0, 0, 64'h1, 64'h0, 64'h0);
        send_msg(1);
        finish_msg();
        expect_byte("w1_b0", 8'h01);
        expect_byte("w1_wrap", 8'h01);

        // Asynchronous reset mid-SHIFT
        configure(6'd8, 0, 0, 64'h07, 64'h0, 64'h0);
        send_byte(msg[0]);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_nib_ready", nib_ready, 0);
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_out_byte", out_byte, 0);
        @(negedge clk);
        rst = 1'b0;
        nib_valid = 1'b1;
        nib_data  = 4'h1;
        tick();
        tick();
        check_eq("arst_stay_not_ready", nib_ready, 0);
        nib_valid = 1'b0;
        configure(6'd8, 0, 0, 64'h07, 64'h0, 64'h0);
        send_msg(9);
        finish_msg();
        expect_byte("arst_crc8", 8'hF4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/crc_serial_engine.md
# crc_serial_engine

- Bit-serial CRC datapath sitting directly downstream of the CRC decelerator top FSM.
- Consumes the latched configuration (width, poly, init, xor, reflect flags) and a nibble-wide message stream.
- Shifts each assembled message byte through the accumulator one bit per clock.
- On request, applies output reflection and final XOR, then presents the CRC one byte at a time with wrap-around.

## Interface
Parameters:
- MAX_WIDTH, 64: accumulator and config width in bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- cfg_width  in  6  CRC width in bits, 1..63; 0 means 64.
- cfg_reflect_in  in  1  feed each message byte LSB first.
- cfg_reflect_out  in  1  bit-reverse the low cfg_width bits of the result.
- cfg_poly, cfg_init, cfg_xor  in  MAX_WIDTH each  polynomial (implicit top bit omitted), initial value, final XOR.
- cfg_load  in  1  pulse: latch all cfg_* inputs, load the accumulator with init, and enter LO.
- nib_valid  in  1  message nibble valid.
- nib_data  in  4  message nibble, low nibble of each byte first.
- nib_ready  out  1  nibble accepted when nib_valid && nib_ready at posedge.
- final_req  in  1  pulse: finish the message and compute the result.
- out_next  in  1  pulse: advance to the next result byte.
- out_byte  out  8  current result byte; 0 outside FINAL.
- out_valid  out  1  high in FINAL.
- busy  out  1  high in SHIFT, or while final_req is pending.

## Operation
- States and transitions:
  - IDLE → LO on cfg_load.
  - LO → HI on accepted nibble; the nibble is stored as bits [3:0].
  - HI → SHIFT on accepted nibble; bits [7:4] complete the byte.
  - SHIFT → LO after 8 steps.
  - FINAL persists until cfg_load.
- nib_ready = state is LO or HI.
- Per step, with b = next message bit (MSB-first, or LSB-first if reflect_in):
  - fb = crc[w-1] ^ b
  - crc = ((crc << 1) ^ (fb ? poly : 0)) & mask
  - mask = (1<<w)-1
- Init, poly and xor are masked to w on load.
- final_req:
  - In LO or HI → FINAL. In HI the stored low nibble is discarded.
  - In SHIFT: set a pending flag; take FINAL when the shift completes, instead of returning to LO.
  - In IDLE or FINAL: ignored.
- On FINAL entry, register the result = (reflect_out ? rev_w(crc) : crc) ^ xor, masked; the byte index resets to 0.
- out_byte = result[8*idx +: 8], least-significant byte first. Byte count nb = ceil(w/8).
- out_next in FINAL: idx = (idx == nb-1) ? 0 : idx+1. out_next is ignored elsewhere.
- Precedence:
  - cfg_load beats everything, in any state including mid-SHIFT: the shift aborts, the pending flag clears, and the state goes to LO.
  - A nibble handshake in the same cycle as final_req is dropped.

## Timing
- Reset values: state IDLE, crc 0, result 0, idx 0, pending 0. Outputs nib_ready 0, out_valid 0, out_byte 0, busy 0.
- cfg_load at edge N: nib_ready is high from cycle N+1.
- High nibble accepted at edge M: SHIFT steps occur at edges M+1..M+8, and nib_ready is high again in cycle M+9.
- Sustained throughput: 1 byte per 10 clocks.
- final_req at edge F in LO/HI: out_valid and a correct out_byte from cycle F+1.
- out_next at edge E: the new byte is visible in cycle E+1.
- Asynchronous rst mid-operation returns every register to its reset value immediately. A fresh cfg_load is required before any nibble is accepted.

## Configuration
- CRC_NIBBLE_STEP_EN defined:
  - SHIFT processes 4 bits per clock, using 4 chained steps in the same order: 2 clocks per byte.
  - High nibble at edge M → nib_ready again in cycle M+3.
  - Results are identical.
- Undefined: 1 bit per clock as above.

## Structure
- crc_pkg holds:
  - the state enum (IDLE, LO, HI, SHIFT, FINAL);
  - MAX_WIDTH default;
  - the mask and bit-reverse-by-width functions.
- One sub-module: crc_step. It is combinational: given crc, poly, mask, w and one data bit, it returns the next crc. It is instantiated 1× or 4× depending on CRC_NIBBLE_STEP_EN.

## Test plan
- CRC-8:
  - Config: w=8, poly 0x07, init 0, xor 0, no reflect.
  - Stimulus: "123456789" sent as nibbles 1,3,2,3,…,9,3, then final_req.
  - Response: out_byte 0xF4; out_next wraps back to 0xF4.
- CRC-16/ARC:
  - Config: w=16, poly 0x8005, init 0, xor 0, reflect both.
  - Stimulus: same message, then final_req.
  - Response: 0x3D, then 0xBB on out_next, then 0x3D again on the next out_next.
- CRC-32:
  - Config: w=32, poly 0x04C11DB7, init/xor 0xFFFFFFFF, reflect both.
  - Stimulus: same message.
  - Response: bytes 0x26, 0x39, 0xF4, 0xCB.
- Abort:
  - Stimulus: cfg_load 3 cycles into SHIFT, then the CRC-8 message again.
  - Response: 0xF4, with no residue from the aborted byte.
- final_req cases:
  - final_req in HI state: the low nibble is discarded, and the result equals the CRC of the complete bytes only.
  - final_req during SHIFT: busy stays high, and FINAL is entered right after the 8th step.
- Reset:
  - Stimulus: rst asserted mid-SHIFT.
  - Response: all outputs 0 immediately; nib_ready stays 0 until cfg_load.
